// File: rtl/wrr_lock_arbiter.sv
// wrr_lock_arbiter
//   Weighted round-robin arbiter with packet lock. Each requester holds a
//   credit counter that is refilled from its weight once no requester that
//   is asking still has credit. A grant is held from selection until the
//   tail flit of the packet is accepted downstream.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req[N]       per-requester request, held for the whole packet
//   last[N]      per-requester tail-flit marker, qualified by a transfer
//   weight[N*WW] packed weights, requester i at [i*WW +: WW]
//   ready        downstream accepts the current flit
//   grant[N]     registered one-hot grant, zero when no grant is held
//   grant_valid  grant held (state LOCKED)
//   grant_idx    binary index of the granted requester, 0 when idle
//
// state  | meaning
// IDLE   | no grant; select next eligible requester or refill credits
// LOCKED | grant held until the granted packet's tail flit transfers

module wrr_lock_arbiter #(
  parameter int N  = 8,
  parameter int WW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         last,
  input  logic [N*WW-1:0]      weight,
  input  logic                 ready,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    grant_nxt;
  logic [IW-1:0]   grant_idx_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [WW-1:0]   credit     [N];
  logic [WW-1:0]   credit_nxt [N];
  logic [N-1:0]    eligible;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic            pkt_end;
  logic [WW-1:0]   credit_dec;
  logic [IW-1:0]   idx_wrap;

  assign grant_valid = (state == LOCKED);
  assign pkt_end     = grant_valid & ready & last[grant_idx];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible[i] = req[i] & (credit[i] != '0);
    end
  end

  // First eligible requester scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    int pos;
    pos       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!sel_found && eligible[pos]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(pos);
      end
    end
  end

  // Saturating decrement of the granted requester's credit.
  assign credit_dec = (credit[grant_idx] != '0) ? credit[grant_idx] - WW'(1) : '0;
  assign idx_wrap   = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    ptr_nxt       = ptr;
    for (int i = 0; i < N; i++) begin
      credit_nxt[i] = credit[i];
    end

    case (state)
      IDLE: begin
        if (req != '0) begin
          if (sel_found) begin
            state_nxt     = LOCKED;
            grant_nxt     = {{(N-1){1'b0}}, 1'b1} << sel_idx;
            grant_idx_nxt = sel_idx;
          end else begin
            // Nobody asking has credit left: refill all, zero weight acts as 1.
            for (int i = 0; i < N; i++) begin
              credit_nxt[i] = (weight[i*WW +: WW] == '0) ? WW'(1) : weight[i*WW +: WW];
            end
          end
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          state_nxt             = IDLE;
          grant_nxt             = '0;
          grant_idx_nxt         = '0;
          credit_nxt[grant_idx] = credit_dec;
          // Stay on this requester while it has credit, otherwise move on.
          ptr_nxt               = (credit_dec == '0) ? idx_wrap : grant_idx;
        end
      end
      default: begin
        state_nxt     = IDLE;
        grant_nxt     = '0;
        grant_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      for (int i = 0; i < N; i++) begin
        credit[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= grant_idx_nxt;
      ptr       <= ptr_nxt;
      for (int i = 0; i < N; i++) begin
        credit[i] <= credit_nxt[i];
      end
    end
  end

endmodule

// File: doc/wrr_lock_arbiter.md
WRR_LOCK_ARBITER -- requirements
Module: wrr_lock_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, number of requesters (legal range 2..32).
REQ-002 SHALL have parameter WW, default 4, width of each per-requester weight and credit counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  N  one bit per requester; held high for the whole packet.
REQ-006 SHALL have port last  input  N  per-requester tail-flit marker, qualified by a transfer.
REQ-007 SHALL have port weight  input  N*WW  packed weights; requester i uses bits [i*WW +: WW].
REQ-008 SHALL have port ready  input  1  downstream accepts the current flit.
REQ-009 SHALL have port grant  output  N  one-hot grant, registered; all zero when no grant.
REQ-010 SHALL have port grant_valid  output  1  high when a grant is held (state LOCKED).
REQ-011 SHALL have port grant_idx  output  $clog2(N)  binary index of the granted requester; 0 when grant_valid is low.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and LOCKED; grant_valid SHALL equal (state==LOCKED).
REQ-013 SHALL keep a WW-bit credit counter per requester and a $clog2(N)-bit rotating pointer ptr.
REQ-014 Eligible(i) SHALL be req[i] & (credit[i] != 0).
REQ-015 In IDLE with at least one eligible requester, the FSM SHALL select the first eligible index scanning ptr, ptr+1, ... mod N, and SHALL register grant, grant_idx and LOCKED on the next edge.
REQ-016 In IDLE with req != 0 and no eligible requester, the FSM SHALL reload every credit[i] from weight[i] (weight 0 loads 1), SHALL issue no grant that cycle, and SHALL stay in IDLE.
REQ-017 In IDLE with req == 0, all state SHALL hold.
REQ-018 A transfer SHALL be defined as grant_valid & ready; packet end SHALL be defined as transfer & last[grant_idx].
REQ-019 In LOCKED, grant SHALL hold unchanged until packet end, regardless of req, last of other requesters, or ready.
REQ-020 On packet end, credit[grant_idx] SHALL decrement by 1 (saturating at 0), and the FSM SHALL return to IDLE on the next edge with grant cleared.
REQ-021 On packet end, ptr SHALL become (grant_idx+1) mod N if the decremented credit is 0, else ptr SHALL equal grant_idx.
REQ-022 Minimum spacing between consecutive grants SHALL be one IDLE cycle; a one-flit packet SHALL occupy exactly one LOCKED cycle when ready is high.
REQ-023 Weight changes SHALL take effect only at the next refill; a granted requester's credit SHALL NOT reload mid-packet.
REQ-024 At most one grant bit SHALL be high in any cycle, and grant SHALL be 0 whenever grant_valid is 0.
REQ-025 Deassertion of req[grant_idx] while LOCKED SHALL be a protocol violation; the arbiter SHALL keep the lock until packet end.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, grant=0, grant_valid=0, grant_idx=0, ptr=0 and all credits=0.
REQ-027 Reset asserted mid-packet SHALL drop the grant immediately, without waiting for the edge.
REQ-028 After reset, the first cycle with req != 0 SHALL perform a refill (REQ-016).

Verification
REQ-029 N=4, all weights=1, req=1111, last=1111, ready=1 from reset release: cycle0 refill, then grant=0001 at cycle2, 0010 at cycle4, 0100 at cycle6, 1000 at cycle8, then refill, then 0001 again.
REQ-030 N=4, weights {w0=3,w1=1,w2=1,w3=1}, all requesting, single-flit packets: grant_idx sequence SHALL be 0,0,0,1,2,3, then a refill cycle, then the sequence repeats.
REQ-031 Lock test: grant to requester 2, ready=0 for 5 cycles with last=0100, then ready=1: grant=0100 held for all 6 cycles; IDLE follows; credit[2] decrements once.
REQ-032 Multi-flit packet: requester 1 sends 4 flits (last only on the 4th), ready=1, req=0011: grant=0010 for exactly 4 cycles, then the next grant goes to requester 0.
REQ-033 Reset mid-packet: assert rst_n=0 while grant=1000 between edges: grant=0 and grant_valid=0 immediately; after release with req=1000, a refill occurs, then grant=1000.
REQ-034 Sparse request: only req[3]=1, weight3=2: grants on requester 3 only; a refill occurs after every 2 packets; grant is never given to a non-requesting index.
